// File: rtl/multi_channel_countdown_timer_pkg.sv
// Shared definitions for the multi-channel countdown timer.
// Holds the channel state encoding and the prescaler width helper.
package multi_channel_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ch_state_e;

  // Prescaler counter width: clog2 of the divide ratio, never below one bit
  function automatic int unsigned presc_width(input int div);
    if (div <= 1) return 1;
    return $clog2(div);
  endfunction

endpackage

// File: rtl/multi_channel_countdown_timer_channel.sv
// One countdown channel: IDLE/RUN/HOLD FSM, tick-driven count, latched reload
// value and mode, and a registered one-cycle done pulse.
module multi_channel_countdown_timer_channel
  import multi_channel_countdown_timer_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             periodic,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  ch_state_e        state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] load_q;
  logic             periodic_q;

  // Priority: abort > start > pause > tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      load_q     <= '0;
      periodic_q <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        count <= '0;
      end else if (start) begin
        if (load_value != '0) begin
          load_q     <= load_value;
          periodic_q <= periodic;
          count      <= load_value;
          state      <= RUN;
        end else begin
          // Zero-length interval expires immediately without entering RUN
          count <= '0;
          state <= IDLE;
          done  <= 1'b1;
        end
      end else if (state != IDLE) begin
        if (pause) begin
          state <= HOLD;
        end else begin
          // Releasing pause resumes counting in the same cycle
          state <= RUN;
          if (tick) begin
            if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else if (count == WIDTH'(1)) begin
              done <= 1'b1;
              if (periodic_q) begin
                count <= load_q;
              end else begin
                count <= '0;
                state <= IDLE;
              end
            end
          end
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign remaining = count;

endmodule

// File: rtl/multi_channel_countdown_timer.sv
// CHANNELS independent countdown timers sharing one free-running tick prescaler.
module multi_channel_countdown_timer
  import multi_channel_countdown_timer_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2,
  parameter int TICK_DIV = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       pause,
  input  logic [CHANNELS-1:0]       abort,
  input  logic [CHANNELS-1:0]       periodic,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS*WIDTH-1:0] remaining
);

  localparam int unsigned PW        = presc_width(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 1 || CHANNELS < 1) begin : g_param_error
    $error("multi_channel_countdown_timer: TICK_DIV and CHANNELS must be >= 1");
  end

  logic [PW-1:0] presc;
  logic          tick;

  // Free-running prescaler; never resynchronised to start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else begin
      presc <= (presc == PS_LAST) ? '0 : presc + PW'(1);
    end
  end

  assign tick = (presc == PS_LAST);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    multi_channel_countdown_timer_channel #(
      .WIDTH(WIDTH)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .load_value(load_value[i*WIDTH +: WIDTH]),
      .start     (start[i]),
      .pause     (pause[i]),
      .abort     (abort[i]),
      .periodic  (periodic[i]),
      .busy      (busy[i]),
      .done      (done[i]),
      .remaining (remaining[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_multi_channel_countdown_timer.sv
// Directed self-checking bench for multi_channel_countdown_timer
// (one instance with TICK_DIV=1, one with TICK_DIV=4).
module tb_multi_channel_countdown_timer;

  localparam int W  = 10;
  localparam int CH = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [CH*W-1:0] load_value, remaining;
  logic [CH-1:0]   start, pause, abort, periodic, busy, done;

  logic [CH*W-1:0] load_value4, remaining4;
  logic [CH-1:0]   start4, pause4, abort4, periodic4, busy4, done4;

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_channel_countdown_timer #(.WIDTH(W), .CHANNELS(CH), .TICK_DIV(1)) dut (
    .clk(clk), .reset(reset), .load_value(load_value), .start(start),
    .pause(pause), .abort(abort), .periodic(periodic), .busy(busy),
    .done(done), .remaining(remaining)
  );

  multi_channel_countdown_timer #(.WIDTH(W), .CHANNELS(CH), .TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .load_value(load_value4), .start(start4),
    .pause(pause4), .abort(abort4), .periodic(periodic4), .busy(busy4),
    .done(done4), .remaining(remaining4)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rem(input int c);
    return int'(remaining[c*W +: W]);
  endfunction

  function automatic int rem4(input int c);
    return int'(remaining4[c*W +: W]);
  endfunction

  task automatic set_load(input int c, input int v);
    load_value[c*W +: W] = W'(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d0, d1, n;
    load_value = '0; start = '0; pause = '0; abort = '0; periodic = '0;
    load_value4 = '0; start4 = '0; pause4 = '0; abort4 = '0; periodic4 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_remaining", int'(remaining), 0);
    reset = 1'b0;
    cyc();

    // Basic one-shot, load 10
    set_load(0, 10); start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    check("t1_busy", int'(busy[0]), 1);
    check("t1_rem_start", rem(0), 10);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      check("t1_rem", rem(0), 10 - i);
      check("t1_no_done", int'(done[0]), 0);
    end
    cyc();
    check("t1_done", int'(done[0]), 1);
    check("t1_rem_end", rem(0), 0);
    check("t1_busy_end", int'(busy[0]), 0);
    cyc();
    check("t1_done_pulse", int'(done[0]), 0);

    // Periodic ch1 load 3 with a 5-cycle pause
    set_load(1, 3); periodic[1] = 1'b1; start[1] = 1'b1;
    cyc();
    start[1] = 1'b0; periodic[1] = 1'b0;
    check("t2_rem_start", rem(1), 3);
    cyc(); cyc();
    check("t2_rem_1", rem(1), 1);
    cyc();
    check("t2_done_a", int'(done[1]), 1);
    check("t2_reload", rem(1), 3);
    cyc(); cyc();
    check("t2_rem_pre_pause", rem(1), 1);
    pause[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t2_pause_rem", rem(1), 1);
      check("t2_pause_busy", int'(busy[1]), 1);
      check("t2_pause_nodone", int'(done[1]), 0);
    end
    pause[1] = 1'b0;
    cyc();
    check("t2_done_b", int'(done[1]), 1);
    check("t2_reload_b", rem(1), 3);
    abort[1] = 1'b1;
    cyc();
    abort[1] = 1'b0;
    check("t2_abort_busy", int'(busy[1]), 0);

    // Prescaler TICK_DIV=4, load 2
    load_value4[0 +: W] = W'(2); start4[0] = 1'b1;
    cyc();
    start4[0] = 1'b0;
    check("t3_rem_start", rem4(0), 2);
    d0 = 0; d1 = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      if (d0 == 0 && rem4(0) == 1) d0 = i;
      if (d1 == 0 && done4[0]) d1 = i;
    end
    check("t3_first_tick_window", int'(d0 >= 1 && d0 <= 4), 1);
    check("t3_tick_gap", d1 - d0, 4);
    check("t3_done_window", int'(d1 >= 5 && d1 <= 8), 1);

    // Abort and restart on ch0
    set_load(0, 10); start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    repeat (3) cyc();
    check("t4_rem_7", rem(0), 7);
    abort[0] = 1'b1;
    cyc();
    abort[0] = 1'b0;
    check("t4_abort_busy", int'(busy[0]), 0);
    check("t4_abort_rem", rem(0), 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (done[0]) n++;
      cyc();
    end
    check("t4_abort_no_done", n, 0);
    set_load(0, 10); start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    cyc(); cyc();
    check("t4_rem_8", rem(0), 8);
    set_load(0, 7); start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    check("t4_restart_rem", rem(0), 7);
    check("t4_restart_nodone", int'(done[0]), 0);
    check("t4_restart_busy", int'(busy[0]), 1);
    cyc();
    check("t4_restart_dec", rem(0), 6);
    start[0] = 1'b1; abort[0] = 1'b1;
    cyc();
    start[0] = 1'b0; abort[0] = 1'b0;
    check("t4_both_busy", int'(busy[0]), 0);
    check("t4_both_rem", rem(0), 0);
    check("t4_both_done", int'(done[0]), 0);

    // Boundary: zero load
    set_load(0, 0); start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    check("t5_zero_done", int'(done[0]), 1);
    check("t5_zero_busy", int'(busy[0]), 0);
    check("t5_zero_rem", rem(0), 0);
    cyc();
    check("t5_zero_pulse", int'(done[0]), 0);

    // Boundary: maximum load
    set_load(0, 1023); start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    n = 0;
    while (!done[0] && n < 1100) begin
      cyc();
      n++;
    end
    check("t5_max_latency", n, 1023);
    check("t5_max_busy", int'(busy[0]), 0);

    // Async reset mid-count
    set_load(0, 100); start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    repeat (5) cyc();
    check("t5_pre_reset_rem", rem(0), 95);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_async_busy", int'(busy), 0);
    check("t5_async_rem", int'(remaining), 0);
    check("t5_async_done", int'(done), 0);
    check("t5_async_busy4", int'(busy4), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc();

    // Independence: loads 4 and 6 started on the same edge
    set_load(0, 4); set_load(1, 6); start = 2'b11;
    cyc();
    start = 2'b00;
    d0 = 0; d1 = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (d0 == 0 && done[0]) d0 = i;
      if (d1 == 0 && done[1]) d1 = i;
    end
    check("t6_done_ch0", d0, 4);
    check("t6_done_ch1", d1, 6);
    set_load(1, 5); start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      start[0] = (i % 2 == 1);
      abort[0] = (i == 3);
      set_load(0, i);
      cyc();
      check("t6_ch1_undisturbed", rem(1), 5 - i);
    end
    start[0] = 1'b0; abort[0] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/multi_channel_countdown_timer.md
Name: multi_channel_countdown_timer

Overview:
- Parametrised successor to the single-channel seconds counter: CHANNELS independent down-counters of WIDTH bits.
- All channels share one prescaler, so each channel counts ticks instead of raw clocks.
- Per channel: load value, start, pause, abort, one-shot/periodic mode, one-cycle done pulse and live remaining count.
- Sits between the control FSMs and the timed outputs (gate/valve/light timers): the FSM requests a timed interval and waits on done.

Parameters:
- WIDTH, 10, bits per channel count and load value (max interval 2^WIDTH-1 ticks).
- CHANNELS, 2, number of independent timer channels (>=1).
- TICK_DIV, 1, clock cycles per count tick (>=1); 1 means decrement every clock.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- load_value  in  CHANNELS*WIDTH  per-channel interval in ticks; channel i at bits [i*WIDTH +: WIDTH].
- start  in  CHANNELS  per-channel start/restart request, level sampled each clk.
- pause  in  CHANNELS  per-channel hold; count frozen while high.
- abort  in  CHANNELS  per-channel cancel.
- periodic  in  CHANNELS  mode: 1 auto-reload on expiry, 0 one-shot; sampled at start.
- busy  out  CHANNELS  channel in RUN or HOLD.
- done  out  CHANNELS  one-cycle pulse on expiry.
- remaining  out  CHANNELS*WIDTH  current count per channel.

Behaviour:
- Reset (async, active-high): prescaler=0; every channel IDLE; count=0; busy=0; done=0; remaining=0; latched load and mode=0.
- Prescaler:
  - Free-running 0..TICK_DIV-1 from reset.
  - tick is high in the cycle the prescaler equals TICK_DIV-1; for TICK_DIV=1 it is always high.
  - Not restarted by start, so the first interval may be short by up to TICK_DIV-1 clocks.
- Channel FSM states: IDLE, RUN, HOLD.
- Priority per channel and cycle: abort > start > pause > tick.
- abort: any state goes to IDLE, count=0, done=0 next cycle, no done pulse. abort in IDLE has no effect.
- start with load_value=N>0: from any state, latch N and periodic, count=N, go to RUN. Starting in RUN or HOLD restarts the interval without a done pulse.
- start with load_value=0: stay or go to IDLE, count=0, done pulse next cycle; zero length never enters RUN.
- RUN, pause=1: go to HOLD, count unchanged. HOLD, pause=0: return to RUN. Ticks arriving in HOLD are lost.
- RUN, tick, count>1: count decrements by 1.
- RUN, tick, count==1: done=1 for exactly the next cycle, then:
  - periodic latched 1: count=latched N, stay RUN.
  - periodic latched 0: count=0, go to IDLE.
- Done timing: with TICK_DIV=1, start sampled at edge k with N gives done high in the cycle after edge k+N, i.e. N clocks.
- done is registered and cycles are back-to-back: periodic with N=1 and TICK_DIV=1 gives done high every cycle.
- start and expiry in the same cycle: start wins, reload, no done pulse.
- busy=1 iff state is RUN or HOLD; remaining=count (registered).
- Arithmetic is unsigned, no wrap: count never decrements below 0.
- Channels are fully independent; only the prescaler is shared.
- Width errors: TICK_DIV<1 or CHANNELS<1 is a static elaboration error.

Decomposition:
- Shared package/header: channel state encoding (IDLE=2'd0, RUN=2'd1, HOLD=2'd2) and a prescaler width constant computed as clog2(TICK_DIV), minimum 1.
- One sub-module, timer_channel: per-channel FSM, count, latched load and mode, done register.
- Top level instantiates CHANNELS copies via generate, plus the shared prescaler.

Test Plan:
- Basic one-shot (WIDTH=10, TICK_DIV=1): reset, then load 10, start ch0 for 1 cycle -> busy high; remaining 10,9,..,1,0; done pulses exactly once 10 clocks after start; busy low with done.
- Periodic with pause: ch1 periodic=1, load 3 -> done every 3 clocks; pause held 5 cycles mid-count -> remaining frozen, next done delayed by exactly 5.
- Prescaler: TICK_DIV=4, load 2 -> done between 5 and 8 clocks after start; remaining decrements only on tick cycles.
- Abort and restart: abort mid-count -> IDLE, remaining 0, no done. start during RUN with load 7 -> count reloads to 7, no done. start and abort together -> IDLE.
- Boundary: load 0 -> done 1 cycle later, busy never high. Load 1023 -> done after 1023 clocks. Async reset mid-count -> all outputs 0 immediately, before the next clk edge.
- Independence: both channels started on the same edge with loads 4 and 6 -> done at clocks 4 and 6; activity on ch0 never disturbs ch1.
